// File: rtl/sdram_write.sv
// SDRAM write-session controller.
// Pulls 4-word bursts from a first-word-fall-through write FIFO and writes
// them to SDRAM. The column advances after every burst. The row and the bank
// advance on page and frame wrap. Between bursts it yields the bus for
// auto-refresh when the arbiter asks for it.
//
// Handshake: wr_req is the bus request. It is registered and goes high the
// cycle after the FSM enters REQ. A single cycle of wr_en while in REQ is the
// grant. wr_req drops the cycle after the grant has been taken.
// The SDRAM command, address and data outputs are all registered, so each one
// appears one cycle after the state/counter value that produces it. This keeps
// data beat 0 on the same bus cycle as its WR command.
module sdram_write #(
    parameter int ROW_ADDR_MAX    = 1440,
    parameter int BURSTS_PER_TRIG = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aref_req,
    input  logic        wr_trig,
    input  logic        wr_en,
    input  logic        flag_rd,
    input  logic [15:0] wfifo_rd_data,
    output logic        wr_req,
    output logic [3:0]  wr_cmd,
    output logic [12:0] wr_addr,
    output logic [1:0]  wr_bank,
    output logic [15:0] wr_data,
    output logic        wfifo_rd_en,
    output logic        flag_wr,
    output logic        flag_wr_end,
    output logic        wr_flag_aref,
    output logic [4:0]  dbg_state
);

    // SDRAM commands, {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    // A10 high selects precharge of all banks
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    // Column of the last burst in a 512-word page
    localparam logic [8:0]  LAST_COL     = 9'd508;

    localparam logic [12:0] ROW_MAX      = 13'(ROW_ADDR_MAX);
    localparam logic [10:0] BURSTS_LAST  = 11'(BURSTS_PER_TRIG - 1);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_REQ  = 5'b00010,
        S_ACT  = 5'b00100,
        S_WR   = 5'b01000,
        S_PRE  = 5'b10000
    } state_t;

    // Why the write loop left WR; decides where PRE goes afterwards
    typedef enum logic [1:0] {
        PR_END  = 2'd0,
        PR_AREF = 2'd1,
        PR_ROW  = 2'd2
    } pre_reason_t;

    state_t      state;
    state_t      state_next;
    pre_reason_t pre_reason;

    logic [1:0]  act_cnt;
    logic [1:0]  burst_cnt;
    logic        pre_cnt;
    logic [8:0]  col_addr;
    logic [12:0] row_addr;
    logic [10:0] bursts_done;

    logic [3:0]  cmd_next;
    logic [12:0] addr_next;

    logic        burst_last;
    logic        page_wrap;
    logic        session_done;
    logic        pre_exit;

    // Decode of events shared by the FSM and the datapath
    always_comb begin
        burst_last   = (state == S_WR) && (burst_cnt == 2'd3);
        page_wrap    = (col_addr == LAST_COL);
        session_done = (bursts_done == BURSTS_LAST);
        pre_exit     = (state == S_PRE) && pre_cnt;
        wfifo_rd_en  = (state == S_WR);
        dbg_state    = state;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the command/address to put on the bus next cycle
    always_comb begin
        state_next = state;
        cmd_next   = CMD_NOP;
        addr_next  = 13'd0;
        case (state)
            S_IDLE: begin
                if (wr_trig && !flag_rd) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_en) begin
                    state_next = S_ACT;
                end
            end
            S_ACT: begin
                if (act_cnt == 2'd1) begin
                    cmd_next  = CMD_ACT;
                    addr_next = row_addr;
                end
                if (act_cnt == 2'd3) begin
                    state_next = S_WR;
                end
            end
            S_WR: begin
                if (burst_cnt == 2'd0) begin
                    cmd_next  = CMD_WR;
                    addr_next = {4'b0000, col_addr};
                end
                // Ending the session beats refresh, and refresh beats a row change
                if (burst_last && (session_done || aref_req || page_wrap)) begin
                    state_next = S_PRE;
                end
            end
            S_PRE: begin
                if (!pre_cnt) begin
                    cmd_next  = CMD_PRE;
                    addr_next = PRE_ALL_ADDR;
                end else begin
                    case (pre_reason)
                        PR_END:  state_next = S_IDLE;
                        PR_AREF: state_next = S_REQ;
                        default: state_next = S_ACT;
                    endcase
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Per-state cycle counters; each restarts from 0 on entry to its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cnt   <= 2'd0;
            burst_cnt <= 2'd0;
            pre_cnt   <= 1'b0;
        end else begin
            act_cnt   <= (state == S_ACT) ? act_cnt + 2'd1 : 2'd0;
            burst_cnt <= (state == S_WR)  ? burst_cnt + 2'd1 : 2'd0;
            pre_cnt   <= (state == S_PRE) ? ~pre_cnt : 1'b0;
        end
    end

    // Address walk: column per burst, row per page, bank ping-pong per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_addr    <= 9'd0;
            row_addr    <= 13'd0;
            wr_bank     <= 2'd0;
            bursts_done <= 11'd0;
            pre_reason  <= PR_END;
        end else if (burst_last) begin
            // The 9-bit column rolls from 508 to 0 by itself
            col_addr    <= col_addr + 9'd4;
            bursts_done <= bursts_done + 11'd1;
            if (page_wrap) begin
                if (row_addr == ROW_MAX) begin
                    row_addr <= 13'd0;
                    wr_bank  <= wr_bank ^ 2'b10;
                end else begin
                    row_addr <= row_addr + 13'd1;
                end
            end
            if (session_done) begin
                pre_reason <= PR_END;
            end else if (aref_req) begin
                pre_reason <= PR_AREF;
            end else begin
                pre_reason <= PR_ROW;
            end
        end else if (pre_exit && (pre_reason == PR_END)) begin
            bursts_done <= 11'd0;
        end
    end

    // Registered SDRAM bus: command, address and data move together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cmd  <= CMD_NOP;
            wr_addr <= 13'd0;
            wr_data <= 16'd0;
        end else begin
            wr_cmd  <= cmd_next;
            wr_addr <= addr_next;
            wr_data <= (state == S_WR) ? wfifo_rd_data : 16'd0;
        end
    end

    // Bus request, session flag and the one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req       <= 1'b0;
            flag_wr      <= 1'b0;
            flag_wr_end  <= 1'b0;
            wr_flag_aref <= 1'b0;
        end else begin
            wr_req       <= (state == S_REQ);
            flag_wr_end  <= pre_exit && (pre_reason == PR_END);
            wr_flag_aref <= pre_exit && (pre_reason == PR_AREF);
            if ((state == S_REQ) && wr_en) begin
                flag_wr <= 1'b1;
            end else if (pre_exit && (pre_reason == PR_END)) begin
                flag_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_write.sv
// Testbench for sdram_write. A small row count makes frame wraps reachable,
// and 80 bursts per session make page wraps fall mid-session.
module tb_sdram_write;

    localparam int ROW_MAX = 2;
    localparam int BPT     = 80;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WRC = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        aref_req = 1'b0;
    logic        wr_trig;
    logic        wr_en;
    logic        flag_rd;
    logic [15:0] wfifo_rd_data = 16'h0;
    logic        wr_req;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        wfifo_rd_en;
    logic        flag_wr;
    logic        flag_wr_end;
    logic        wr_flag_aref;
    logic [4:0]  dbg_state;

    sdram_write #(.ROW_ADDR_MAX(ROW_MAX), .BURSTS_PER_TRIG(BPT)) dut (
        .clk(clk), .rst(rst), .aref_req(aref_req), .wr_trig(wr_trig),
        .wr_en(wr_en), .flag_rd(flag_rd), .wfifo_rd_data(wfifo_rd_data),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .wr_data(wr_data), .wfifo_rd_en(wfifo_rd_en), .flag_wr(flag_wr),
        .flag_wr_end(flag_wr_end), .wr_flag_aref(wr_flag_aref),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];     // {cmd, addr, bank}
    logic [15:0] exp_d_q[$];   // data beats in bus order
    logic [15:0] fifo_q[$];    // contents of the modelled write FIFO
    logic        pop_pend = 1'b0;
    bit          mon_en = 1'b0;
    bit          arb_auto = 1'b0;
    int          aref_target = -1;  // absolute WR index that raises aref_req
    int          burst_idx = 0;     // WR commands seen so far
    int          end_cnt = 0;
    int          aref_cnt = 0;
    int          cyc = 0;
    int          m_row = 0;
    int          m_col = 0;
    int          m_bank = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] pack_cmd(input logic [3:0] c, input int a, input int b);
        return {c, 13'(a), 2'(b)};
    endfunction

    // Reference model: expected command stream and data for one session,
    // derived from the address-walk rules (4 words per burst, 512-word page).
    task automatic build_session(input int aref_t, output int n_aref);
        logic [15:0] w;
        bit wrap;
        n_aref = 0;
        exp_q.push_back(pack_cmd(ACT, m_row, m_bank));
        for (int i = 0; i < BPT; i++) begin
            exp_q.push_back(pack_cmd(WRC, m_col, m_bank));
            for (int j = 0; j < 4; j++) begin
                w = 16'($urandom);
                fifo_q.push_back(w);
                exp_d_q.push_back(w);
            end
            wrap  = (m_col == 508);
            m_col = (m_col + 4) % 512;
            if (wrap) begin
                if (m_row == ROW_MAX) begin
                    m_row  = 0;
                    m_bank = m_bank ^ 2;
                end else begin
                    m_row = m_row + 1;
                end
            end
            if (i == BPT - 1) begin
                exp_q.push_back(pack_cmd(PRE, 13'h400, 0));
            end else if (i == aref_t || wrap) begin
                exp_q.push_back(pack_cmd(PRE, 13'h400, 0));
                exp_q.push_back(pack_cmd(ACT, m_row, m_bank));
                if (i == aref_t) n_aref++;
            end
        end
    endtask

    // ---------------- write FIFO model (first-word fall-through) ----------------
    always @(negedge clk) pop_pend = wfifo_rd_en;

    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pend = 1'b0;
        wfifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
    end

    // ---------------- arbiter driver: grant 1..3 cycles after wr_req ----------------
    initial begin
        wr_en = 1'b0;
        forever begin
            @(negedge clk);
            if (arb_auto && wr_req && !rst) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                while (wr_req) @(negedge clk);
            end
        end
    end

    // ---------------- bus monitor / scoreboard ----------------
    int          beat_left = 0;
    logic [3:0]  last_cmd = NOP;
    int          last_cyc = 0;
    logic [18:0] e;
    logic [15:0] ed;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            aref_req  = 1'b0;
            beat_left = 0;
            last_cmd  = NOP;
        end else if (!rst) begin
            if (wr_cmd != NOP) begin
                check("flag_wr_during_cmd", flag_wr, 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got cmd %b addr 0x%0h, expected no command", wr_cmd, wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_cmd == PRE) check("pre_cmd_addr", {wr_cmd, wr_addr}, e[18:2]);
                    else check("cmd_addr_bank", {wr_cmd, wr_addr, wr_bank}, e);
                end
                if (wr_cmd == WRC) begin
                    if (last_cmd == ACT) check("act_to_wr_gap", cyc - last_cyc, 3);
                    if (last_cmd == WRC) check("wr_to_wr_gap", cyc - last_cyc, 4);
                    if (burst_idx == aref_target) aref_req = 1'b1;
                    burst_idx++;
                    beat_left = 4;
                end
                last_cmd = wr_cmd;
                last_cyc = cyc;
            end
            if (beat_left > 0) begin
                if (exp_d_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data: got 0x%0h, expected no beat", wr_data);
                end else begin
                    ed = exp_d_q.pop_front();
                    check("wr_data", wr_data, ed);
                end
                beat_left--;
            end
            if (wr_flag_aref) begin
                aref_cnt++;
                aref_req = 1'b0;
                check("flag_wr_through_aref", flag_wr, 1'b1);
            end
            if (flag_wr_end) begin
                end_cnt++;
                aref_req = 1'b0;
                check("flag_wr_clear_at_end", flag_wr, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string tag);
        check({tag, "_cmd"}, wr_cmd, NOP);
        check({tag, "_addr"}, wr_addr, 13'h0);
        check({tag, "_data"}, wr_data, 16'h0);
        check({tag, "_bank"}, wr_bank, 2'd0);
        check({tag, "_wr_req"}, wr_req, 1'b0);
        check({tag, "_rd_en"}, wfifo_rd_en, 1'b0);
        check({tag, "_flag_wr"}, flag_wr, 1'b0);
        check({tag, "_flag_end"}, flag_wr_end, 1'b0);
        check({tag, "_flag_aref"}, wr_flag_aref, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one full session; ok=0 when the DUT never started or never finished
    task automatic run_session(input int aref_t, output bit ok);
        int n_aref;
        int e0;
        int a0;
        ok = 1'b1;
        e0 = end_cnt;
        a0 = aref_cnt;
        aref_target = (aref_t < 0) ? -1 : burst_idx + aref_t;
        build_session(aref_t, n_aref);
        if ($urandom_range(0, 1) == 1) begin
            flag_rd = 1'b1;
            wr_trig = 1'b1;
            repeat (5) @(negedge clk);
            check("flag_rd_blocks_req", wr_req, 1'b0);
            check("flag_rd_blocks_flag", flag_wr, 1'b0);
        end
        flag_rd = 1'b0;
        wr_trig = 1'b1;
        for (int k = 0; k < 200 && !flag_wr; k++) @(negedge clk);
        check("session_start", flag_wr, 1'b1);
        // trigger drops mid-session; the session still has to complete
        wr_trig = 1'b0;
        if (!flag_wr) begin
            ok = 1'b0;
            return;
        end
        for (int k = 0; k < 3000 && end_cnt == e0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("session_end_pulses", end_cnt - e0, 1);
        if (end_cnt == e0) begin
            ok = 1'b0;
            return;
        end
        check("cmds_left", exp_q.size(), 0);
        check("beats_left", exp_d_q.size(), 0);
        check("aref_pulses", aref_cnt - a0, n_aref);
        check("idle_flag_wr", flag_wr, 1'b0);
        check("idle_wr_req", wr_req, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic trig;
        logic rd;
        logic exp_req;
    } vec_t;

    vec_t tbl[4];
    bit   ok;

    initial begin
        rst     = 1'b1;
        wr_trig = 1'b0;
        flag_rd = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Session-start gating from IDLE: only wr_trig without flag_rd requests the bus
        tbl[0] = '{trig: 1'b0, rd: 1'b0, exp_req: 1'b0};
        tbl[1] = '{trig: 1'b0, rd: 1'b1, exp_req: 1'b0};
        tbl[2] = '{trig: 1'b1, rd: 1'b1, exp_req: 1'b0};
        tbl[3] = '{trig: 1'b1, rd: 1'b0, exp_req: 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_trig = tbl[i].trig;
            flag_rd = tbl[i].rd;
            repeat (3) @(negedge clk);
            check("gate_wr_req", wr_req, tbl[i].exp_req);
            check("gate_cmd_nop", wr_cmd, NOP);
            check("gate_addr_zero", wr_addr, 13'h0);
            check("gate_flag_wr", flag_wr, 1'b0);
            wr_trig = 1'b0;
            flag_rd = 1'b0;
            pulse_reset();
        end

        // Full sessions: clean, end-with-refresh, refresh at burst 10, then random
        mon_en   = 1'b1;
        arb_auto = 1'b1;
        m_row    = 0;
        m_col    = 0;
        m_bank   = 0;
        ok       = 1'b1;
        for (int s = 0; s < 12 && ok; s++) begin
            int at;
            if (s == 0) at = -1;
            else if (s == 1) at = BPT - 1;
            else if (s == 2) at = 10;
            else at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, BPT - 1) : -1;
            run_session(at, ok);
        end

        // Reset in the middle of a burst: everything returns to reset values
        // at once and no precharge follows.
        if (ok) begin
            int b0;
            int n_aref;
            b0 = burst_idx;
            aref_target = -1;
            build_session(-1, n_aref);
            wr_trig = 1'b1;
            for (int k = 0; k < 300 && burst_idx < b0 + 3; k++) @(negedge clk);
            check("reached_wr", burst_idx >= b0 + 3, 1'b1);
            wr_trig = 1'b0;
            mon_en  = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
            #1 check_reset("rst_mid_wr");
            exp_q.delete();
            exp_d_q.delete();
            fifo_q.delete();
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check("no_pre_after_rst", wr_cmd, NOP);
            end
            m_row  = 0;
            m_col  = 0;
            m_bank = 0;
            mon_en = 1'b1;
            run_session(-1, ok);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_write.md
SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 Parameter ROW_ADDR_MAX, default 1440: last row written before the frame wraps.
REQ-002 Parameter BURSTS_PER_TRIG, default 64, legal 1..1024: 4-word bursts written per session.
REQ-003 clk  in  1  sole clock; all logic rises on posedge clk.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 aref_req  in  1  auto-refresh pending, from the arbiter.
REQ-006 wr_trig  in  1  write session request, level; write FIFO holds at least one session of data.
REQ-007 wr_en  in  1  arbiter grant of the SDRAM bus.
REQ-008 flag_rd  in  1  read session in progress; blocks session start.
REQ-009 wfifo_rd_data  in  16  first-word-fall-through write FIFO output.
REQ-010 wr_req  out  1  bus request to the arbiter.
REQ-011 wr_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}: NOP 0111, ACT 0011, WR 0100, PRE 0010.
REQ-012 wr_addr  out  13  SDRAM address bus.
REQ-013 wr_bank  out  2  SDRAM bank.
REQ-014 wr_data  out  16  SDRAM DQ write data.
REQ-015 wfifo_rd_en  out  1  write FIFO pop.
REQ-016 flag_wr  out  1  write session in progress.
REQ-017 flag_wr_end  out  1  one-cycle pulse, session complete.
REQ-018 wr_flag_aref  out  1  one-cycle pulse, bus released for refresh.

Function
REQ-019 States, one-hot: IDLE, REQ, ACT, WR, PRE.
REQ-020 IDLE->REQ when wr_trig=1 and flag_rd=0; otherwise the FSM holds IDLE.
REQ-021 REQ: wr_req registered high from the cycle after entry until the cycle after wr_en=1; on wr_en=1 the FSM moves to ACT.
REQ-022 flag_wr sets on the clock where state=REQ and wr_en=1, clears on PRE->IDLE, and stays high through refresh interruptions.
REQ-023 ACT lasts 4 cycles (act_cnt 0..3); ACT command issued at act_cnt=1 with wr_addr=row_addr; NOP otherwise; then ->WR.
REQ-024 WR: burst_cnt cycles 0..3; WR command with wr_addr={4'b0,col_addr} at burst_cnt=0; NOP at 1..3.
REQ-025 wfifo_rd_en is combinational, high every cycle with state=WR; wr_data is registered from wfifo_rd_data, so beat 0 aligns with the WR command.
REQ-026 After each burst: col_addr += 4; bursts_done += 1.
REQ-027 Page wrap: a burst at col 508 sets col_addr to 0 and increments row_addr.
REQ-028 Frame wrap: if row_addr=ROW_ADDR_MAX at that point, row_addr goes to 0 and wr_bank toggles 0<->2 (ping-pong).
REQ-029 WR exit at burst_cnt=3, priority order:
- bursts_done reaches BURSTS_PER_TRIG -> PRE (end);
- aref_req=1 -> PRE (refresh);
- page wrap -> PRE (row change);
- otherwise stay in WR.
REQ-030 PRE lasts 2 cycles: cycle 1 drives PRE with wr_addr=13'h0400 (A10, all banks); cycle 2 drives NOP.
REQ-031 PRE exits:
- end -> IDLE, with flag_wr_end pulsed and bursts_done cleared;
- refresh -> REQ, with wr_flag_aref pulsed;
- row change -> ACT.
REQ-032 Simultaneous end and aref_req: end wins; refresh is left to the arbiter.
REQ-033 wr_trig dropping mid-session has no effect; the session completes.
REQ-034 wr_addr is 0 and wr_cmd is NOP in IDLE and REQ.

Reset
REQ-035 rst=1 forces, immediately:
- state=IDLE and all counters=0;
- row_addr, col_addr and wr_bank = 0;
- wr_cmd=NOP, wr_addr=0, wr_data=0;
- all flags, wr_req and wfifo_rd_en = 0.
REQ-036 Reset mid-burst abandons the burst; no PRE is issued.

Verification
REQ-037 wr_trig=1, flag_rd=0, wr_en one cycle after wr_req -> ACT with addr 0, then 64 WR commands at col 0,4,...,252, then PRE addr 0x400, flag_wr_end pulse, col_addr=256.
REQ-038 Second session -> cols 256..508; a page wrap coincides with end; row_addr=1; FSM to IDLE, not ACT.
REQ-039 BURSTS_PER_TRIG=80, col start 256 -> PRE after col 508, ACT row+1, WR from col 0; 80 bursts total, one PRE at end.
REQ-040 aref_req raised during burst 10 -> burst completes, PRE, wr_flag_aref pulse, wr_req reasserts, resume at next column; flag_wr stays 1.
REQ-041 Start row=1440, col=508 -> after burst: row 0, col 0, wr_bank 2; repeat the wrap -> wr_bank 0.
REQ-042 flag_rd=1 with wr_trig=1 -> stays IDLE; rst pulse in WR -> all outputs at reset values the same cycle.
